// File: rtl/serial_alu_seq_pkg.sv
// Shared definitions for the bit-serial ALU sequencer.
//   - OP_* : 3-bit opcode encodings driven on the op port
//   - state_t : sequencer FSM states
//   - uses_carry() : true for opcodes that propagate a carry chain
package serial_alu_seq_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_SLT  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_NAND = 3'b101;
    localparam logic [2:0] OP_NOR  = 3'b110;
    localparam logic [2:0] OP_OR   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // ADD, SUB and SLT are the arithmetic ops that chain a carry bit to bit.
    function automatic logic uses_carry(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/serial_alu_slice.sv
// One-bit ALU slice, purely combinational.
//   op   : opcode (OP_*)
//   a, b : operand bits
//   cin  : carry in (only meaningful for ADD/SUB/SLT)
//   out  : result bit
//   cout : carry out (0 for logic ops)
module serial_alu_slice
    import serial_alu_seq_pkg::*;
(
    input  logic [2:0] op,
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    output logic       out,
    output logic       cout
);

    logic b_eff;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        out   = 1'b0;
        cout  = 1'b0;
        // Subtraction is a + ~b + 1; the +1 arrives as the initial carry.
        b_eff = (op == OP_SUB || op == OP_SLT) ? ~b : b;
        case (op)
            OP_ADD, OP_SUB, OP_SLT: begin
                out  = a ^ b_eff ^ cin;
                cout = (a & b_eff) | (a & cin) | (b_eff & cin);
            end
            OP_XOR:  out = a ^ b;
            OP_AND:  out = a & b;
            OP_NAND: out = ~(a & b);
            OP_NOR:  out = ~(a | b);
            OP_OR:   out = a | b;
            default: out = 1'b0;
        endcase
    end

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: accepts a WIDTH-bit operand pair and opcode,
// walks one serial_alu_slice LSB-first for WIDTH cycles and presents the
// assembled result and flags with a one-cycle done pulse.
//   clk, reset_n        : clock, asynchronous active-low reset
//   start, op, a, b     : request and operands, sampled when busy=0
//   busy                : high while bits are being processed
//   done                : one-cycle pulse when result/flags update
//   result              : registered result, held until the next done
//   carryout, overflow  : ADD/SUB carry, ADD/SUB/SLT signed overflow
//   zero                : result == 0
module serial_alu_seq
    import serial_alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    state_t           state_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_sh_q, b_sh_q, res_sh_q;
    logic [CNTW-1:0]  cnt_q;
    logic             carry_q;
    logic             busy_q, done_q, carryout_q, overflow_q, zero_q;
    logic [WIDTH-1:0] result_q;

    logic             slice_out, slice_cout;
    logic [WIDTH-1:0] result_d;
    logic             carryout_d, overflow_d;

    serial_alu_slice u_slice (
        .op   (op_q),
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .out  (slice_out),
        .cout (slice_cout)
    );

    // Final result/flags, valid on the last RUN cycle. At that point carry_q is
    // the carry entering the MSB slice and slice_cout is the final carry.
    always_comb begin
        result_d   = {slice_out, res_sh_q[WIDTH-1:1]};
        carryout_d = 1'b0;
        overflow_d = 1'b0;
        case (op_q)
            OP_ADD, OP_SUB: begin
                carryout_d = slice_cout;
                overflow_d = carry_q ^ slice_cout;
            end
            OP_SLT: begin
                overflow_d = carry_q ^ slice_cout;
                // Signed less-than is the difference's sign corrected by overflow.
                result_d   = {{(WIDTH-1){1'b0}}, slice_out ^ (carry_q ^ slice_cout)};
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the shift registers are cleared too, so an aborted operation leaves no stale bits behind.
            state_q    <= S_IDLE;
            op_q       <= OP_ADD;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            res_sh_q   <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            carryout_q <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        op_q     <= op;
                        a_sh_q   <= a;
                        b_sh_q   <= b;
                        res_sh_q <= '0;
                        cnt_q    <= '0;
                        carry_q  <= (op == OP_SUB) || (op == OP_SLT);
                        busy_q   <= 1'b1;
                        state_q  <= S_RUN;
                    end else begin
                        state_q  <= S_IDLE;
                    end
                end
                S_RUN: begin
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    res_sh_q <= {slice_out, res_sh_q[WIDTH-1:1]};
                    cnt_q    <= cnt_q + CNTW'(1);
                    if (uses_carry(op_q)) begin
                        carry_q <= slice_cout;
                    end
                    if (cnt_q == CNTW'(WIDTH - 1)) begin
                        result_q   <= result_d;
                        carryout_q <= carryout_d;
                        overflow_q <= overflow_d;
                        zero_q     <= (result_d == '0);
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= S_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign carryout = carryout_q;
    assign overflow = overflow_q;
    assign zero     = zero_q;

endmodule
